pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter NUM_STAGES, default 3: tracked stages after ID (1=EX, 2=MEM, NUM_STAGES=WB); legal range 2..8.
REQ-002 Parameter IDX_W, default 5: register index width.
REQ-003 Parameter LOAD_READY_STAGE, default 2: first stage index at which load data is forwardable.
REQ-004 Parameter FWD_EN, default 1: 1 enables forwarding, 0 means stall-only mode.
REQ-005 Parameter FLUSH_STAGES, default 2: number of youngest tracked entries killed by a flush.
REQ-006 Parameter CNT_W, default 32: stall counter width.
REQ-007 The block SHALL have one clock; reset is synchronous and active-high:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1_idx, id_rs2_idx  in  IDX_W  source indices
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd_idx  in  IDX_W  destination index
- id_reg_wr  in  1  instruction writes rd
- id_rd_mem  in  1  instruction is a load
- flush  in  1  taken branch resolved; kill younger instructions
- mem_wait  in  1  data memory busy; freeze pipeline
- stall  out  1  hold PC and IF/ID, bubble into ID/EX
- fwd_a_sel, fwd_b_sel  out  $clog2(NUM_STAGES)  operand source: 0 = register file, k = result of instruction now in stage k
- stall_cnt  out  CNT_W  saturating count of stall cycles

Function
REQ-008 Tracking table SHALL hold entries 1..NUM_STAGES, each {valid, rd, is_load}; entry k is the instruction currently in stage k.
REQ-009 Each cycle with mem_wait=0: entry[k+1] <= entry[k]; entry[1] <= ID instruction if id_valid & ~stall & ~flush & id_reg_wr & rd!=0, else bubble; entry[NUM_STAGES] retires.
REQ-010 mem_wait=1 SHALL freeze the table and force stall=1.
REQ-011 A source matches entry k when: source used, entry valid, rd equal, rd!=0, k<NUM_STAGES. The WB stage never matches, because the register file writes through.
REQ-012 On multiple matches, the smallest k (youngest producer) SHALL win.
REQ-013 With FWD_EN=1: fwd_x_sel=k of the winning match, else 0. Stall is required if the winner is_load and k<LOAD_READY_STAGE.
REQ-014 With FWD_EN=0: fwd_x_sel SHALL be 0. Stall is required on any match.
REQ-015 stall is combinational from the table, ID inputs and mem_wait. Stall and fwd outputs SHALL be 0 when id_valid=0, except that mem_wait still forces stall.
REQ-016 flush with mem_wait=0: next-state entries 1..FLUSH_STAGES SHALL be bubbles; entries above FLUSH_STAGES shift normally; flush overrides stall for that cycle.
REQ-017 flush with mem_wait=1: a pending-flush flag is set and applied per REQ-016 on the first cycle mem_wait=0. A flush then coincident with the pending flag counts once.
REQ-018 stall_cnt SHALL increment in each cycle stall=1 and saturate at all-ones.

Reset
REQ-019 rst=1 SHALL clear all entries to invalid, clear the pending-flush flag and set stall_cnt=0. Outputs are then stall=0 (if mem_wait=0) and fwd sels=0.
REQ-020 rst SHALL override flush, mem_wait and ID inputs in the same cycle. Mid-operation reset discards all tracked producers.

Structure
REQ-021 A shared package SHALL hold the entry struct typedef and the fwd-select encoding constants (FWD_RF=0).
REQ-022 One sub-module, hazard_match (per-operand priority match over the table), SHALL be instantiated twice (rs1, rs2).
REQ-023 Parameter legality (LOAD_READY_STAGE<=NUM_STAGES, FLUSH_STAGES<=NUM_STAGES) SHALL be checked at elaboration.

Verification
REQ-024 Defaults: add x5 issued, next cycle ID reads rs1=x5 -> stall=0, fwd_a_sel=1; one cycle later -> fwd_a_sel=2; two cycles later -> 0.
REQ-025 Defaults: load x7, then ID reads rs2=x7 -> stall=1 for exactly 1 cycle, then fwd_b_sel=2; stall_cnt=1.
REQ-026 FWD_EN=0: add x3, dependent reads x3 -> stall=1 for 2 cycles, then fwd sel 0.
REQ-027 Writes to x9 at stages 1 and 2, ID reads x9 -> fwd_a_sel=1; rd=x0 producer -> no stall, sel 0.
REQ-028 flush with load x4 in entry 1 -> next cycle reader of x4 sees stall=0, sel 0. The same flush during 3 cycles of mem_wait -> stall held 3 cycles, the table frozen, the flush applied on release.
REQ-029 Preload stall_cnt=2^CNT_W-2 (CNT_W=4), stall 3 cycles -> stall_cnt=15 held. rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: tracking-table entry layout and
// forwarding-select encoding.
package pipe_hazard_unit_pkg;

    // Register indices are zero-extended into a fixed-width field so the entry
    // type can live in a package; the top rejects IDX_W wider than this.
    localparam int RD_MAX_W = 16;

    // fwd select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } hz_entry_t;

    localparam hz_entry_t HZ_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Per-operand priority match of one ID source against the tracking table;
// produces the forwarding select and whether this operand needs a stall.
module hazard_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int IDX_W            = 5,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FWD_EN           = 1,
    parameter int SEL_W            = 2
) (
    input  logic                        id_valid,
    input  logic                        src_used,
    input  logic [IDX_W-1:0]            src_idx,
    input  hz_entry_t [NUM_STAGES-1:0]  entries,
    output logic [SEL_W-1:0]            fwd_sel,
    output logic                        need_stall
);

    logic [RD_MAX_W-1:0] src_ext;
    logic                hit;
    logic                hit_load;
    int                  hit_stage;

    assign src_ext = RD_MAX_W'(src_idx);

    always_comb begin
        hit       = 1'b0;
        hit_load  = 1'b0;
        hit_stage = 0;
        // Scan oldest to youngest so the youngest producer is the last writer.
        // The WB entry is skipped: the register file writes through.
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (src_used && entries[k-1].valid &&
                (entries[k-1].rd == src_ext) && (src_ext != '0)) begin
                hit       = 1'b1;
                hit_load  = entries[k-1].is_load;
                hit_stage = k;
            end
        end

        fwd_sel    = SEL_W'(FWD_RF);
        need_stall = 1'b0;
        if (id_valid && hit) begin
            if (FWD_EN != 0) begin
                fwd_sel    = SEL_W'(hit_stage);
                need_stall = hit_load && (hit_stage < LOAD_READY_STAGE);
            end else begin
                need_stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Data-hazard unit: tracks destination registers of in-flight instructions,
// selects forwarding sources for the ID operands and raises stall.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int IDX_W            = 5,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FWD_EN           = 1,
    parameter int FLUSH_STAGES     = 2,
    parameter int CNT_W            = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [IDX_W-1:0]              id_rs1_idx,
    input  logic [IDX_W-1:0]              id_rs2_idx,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [IDX_W-1:0]              id_rd_idx,
    input  logic                          id_reg_wr,
    input  logic                          id_rd_mem,
    input  logic                          flush,
    input  logic                          mem_wait,
    output logic                          stall,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_a_sel,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_b_sel,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int SEL_W = $clog2(NUM_STAGES);

    if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("pipe_hazard_unit: NUM_STAGES must be within 2..8");
    end
    if (LOAD_READY_STAGE < 1 || LOAD_READY_STAGE > NUM_STAGES) begin : g_bad_load_ready
        $error("pipe_hazard_unit: LOAD_READY_STAGE must be within 1..NUM_STAGES");
    end
    if (FLUSH_STAGES < 0 || FLUSH_STAGES > NUM_STAGES) begin : g_bad_flush_stages
        $error("pipe_hazard_unit: FLUSH_STAGES must be within 0..NUM_STAGES");
    end
    if (IDX_W < 1 || IDX_W > RD_MAX_W) begin : g_bad_idx_w
        $error("pipe_hazard_unit: IDX_W exceeds the entry rd field");
    end

    // entries_q[k-1] is the instruction currently in stage k (1 = EX).
    hz_entry_t [NUM_STAGES-1:0] entries_q, entries_d;
    logic                       flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

    logic      stall_a, stall_b;
    logic      flush_now;
    hz_entry_t new_entry;

    hazard_match #(
        .NUM_STAGES       (NUM_STAGES),
        .IDX_W            (IDX_W),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_EN           (FWD_EN),
        .SEL_W            (SEL_W)
    ) u_match_a (
        .id_valid   (id_valid),
        .src_used   (id_rs1_used),
        .src_idx    (id_rs1_idx),
        .entries    (entries_q),
        .fwd_sel    (fwd_a_sel),
        .need_stall (stall_a)
    );

    hazard_match #(
        .NUM_STAGES       (NUM_STAGES),
        .IDX_W            (IDX_W),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_EN           (FWD_EN),
        .SEL_W            (SEL_W)
    ) u_match_b (
        .id_valid   (id_valid),
        .src_used   (id_rs2_used),
        .src_idx    (id_rs2_idx),
        .entries    (entries_q),
        .fwd_sel    (fwd_b_sel),
        .need_stall (stall_b)
    );

    // stall=1 means the ID instruction is not accepted this cycle: PC and
    // IF/ID hold and a bubble enters EX; the producer side never waits on it.
    assign stall     = mem_wait | stall_a | stall_b;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        entries_d    = entries_q;
        flush_pend_d = flush_pend_q;
        stall_cnt_d  = stall_cnt_q;
        flush_now    = flush | flush_pend_q;

        new_entry = HZ_BUBBLE;
        if (id_valid && !stall && !flush_now && id_reg_wr && (id_rd_idx != '0)) begin
            new_entry.valid   = 1'b1;
            new_entry.rd      = RD_MAX_W'(id_rd_idx);
            new_entry.is_load = id_rd_mem;
        end

        if (mem_wait) begin
            // Table frozen; a flush seen now is remembered for the release cycle.
            flush_pend_d = flush_now;
        end else begin
            flush_pend_d = 1'b0;
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                entries_d[k] = entries_q[k-1];
            end
            entries_d[0] = new_entry;
            if (flush_now) begin
                for (int k = 0; k < FLUSH_STAGES; k++) begin
                    entries_d[k] = HZ_BUBBLE;
                end
            end
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q    <= '0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            entries_q    <= entries_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default, stall-only and 4-bit-counter
// instances share stimulus; expectations are queued and checked on negedge.
module tb_pipe_hazard_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_idx, id_rs2_idx, id_rd_idx;
    logic       id_rs1_used, id_rs2_used;
    logic       id_reg_wr, id_rd_mem;
    logic       flush, mem_wait;

    logic        stall_d, stall_n, stall_c;
    logic [1:0]  a_d, b_d, a_n, b_n, a_c, b_c;
    logic [31:0] cnt_d, cnt_n;
    logic [3:0]  cnt_c;

    localparam logic [3:0] M_S   = 4'b1000;
    localparam logic [3:0] M_A   = 4'b0100;
    localparam logic [3:0] M_B   = 4'b0010;
    localparam logic [3:0] M_C   = 4'b0001;
    localparam logic [3:0] M_ALL = 4'b1111;

    typedef struct packed {
        logic [1:0]  dut;
        logic [3:0]  mask;
        logic        stall;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    num_checks;
    int    num_fail;

    pipe_hazard_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
        .flush(flush), .mem_wait(mem_wait),
        .stall(stall_d), .fwd_a_sel(a_d), .fwd_b_sel(b_d), .stall_cnt(cnt_d)
    );

    pipe_hazard_unit #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
        .flush(flush), .mem_wait(mem_wait),
        .stall(stall_n), .fwd_a_sel(a_n), .fwd_b_sel(b_n), .stall_cnt(cnt_n)
    );

    pipe_hazard_unit #(.CNT_W(4)) u_cnt4 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
        .flush(flush), .mem_wait(mem_wait),
        .stall(stall_c), .fwd_a_sel(a_c), .fwd_b_sel(b_c), .stall_cnt(cnt_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input int r1, input logic u1,
                          input int r2, input logic u2,
                          input int d, input logic w, input logic ld);
        id_valid    = v;
        id_rs1_idx  = 5'(r1);
        id_rs1_used = u1;
        id_rs2_idx  = 5'(r2);
        id_rs2_used = u2;
        id_rd_idx   = 5'(d);
        id_reg_wr   = w;
        id_rd_mem   = ld;
    endtask

    task automatic idle_in();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        flush    = 1'b0;
        mem_wait = 1'b0;
    endtask

    task automatic issue(input int d, input logic ld);
        set_in(1'b1, 0, 1'b0, 0, 1'b0, d, 1'b1, ld);
    endtask

    task automatic read_srcs(input int r1, input logic u1, input int r2, input logic u2);
        set_in(1'b1, r1, u1, r2, u2, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_out(input string nm, input int dut, input logic [3:0] mask,
                              input logic s, input int a, input int b, input int c);
        exp_t e;
        e.dut   = 2'(dut);
        e.mask  = mask;
        e.stall = s;
        e.a     = 32'(a);
        e.b     = 32'(b);
        e.cnt   = 32'(c);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // scoreboard / monitor
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    exp_t        mon_e;
    string       mon_nm;
    logic [31:0] act_s, act_a, act_b, act_c;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            case (mon_e.dut)
                2'd1:    begin act_s = 32'(stall_n); act_a = 32'(a_n); act_b = 32'(b_n); act_c = cnt_n;        end
                2'd2:    begin act_s = 32'(stall_c); act_a = 32'(a_c); act_b = 32'(b_c); act_c = 32'(cnt_c); end
                default: begin act_s = 32'(stall_d); act_a = 32'(a_d); act_b = 32'(b_d); act_c = cnt_d;        end
            endcase
            if (mon_e.mask[3]) cmp({mon_nm, "_stall"}, act_s, 32'(mon_e.stall));
            if (mon_e.mask[2]) cmp({mon_nm, "_fwd_a"}, act_a, mon_e.a);
            if (mon_e.mask[1]) cmp({mon_nm, "_fwd_b"}, act_b, mon_e.b);
            if (mon_e.mask[0]) cmp({mon_nm, "_cnt"},   act_c, mon_e.cnt);
        end
    end

    // stimulus
    initial begin
        num_checks = 0;
        num_fail   = 0;
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state on every instance
        expect_out("rst_def", 0, M_ALL, 1'b0, 0, 0, 0);
        expect_out("rst_nf",  1, M_ALL, 1'b0, 0, 0, 0);
        expect_out("rst_c4",  2, M_ALL, 1'b0, 0, 0, 0);
        tick();

        // ALU producer x5 walks EX -> MEM -> WB
        do_reset();
        issue(5, 1'b0);
        tick();
        read_srcs(5, 1'b1, 0, 1'b0); expect_out("alu_ex",  0, M_ALL, 1'b0, 1, 0, 0); tick();
        read_srcs(5, 1'b1, 0, 1'b0); expect_out("alu_mem", 0, M_ALL, 1'b0, 2, 0, 0); tick();
        read_srcs(5, 1'b1, 0, 1'b0); expect_out("alu_wb",  0, M_ALL, 1'b0, 0, 0, 0); tick();

        // load-use on rs2: one stall cycle then forward from MEM
        do_reset();
        issue(7, 1'b1);
        tick();
        read_srcs(0, 1'b0, 7, 1'b1); expect_out("ld_use", 0, M_S | M_B | M_C, 1'b1, 0, 1, 0); tick();
        read_srcs(0, 1'b0, 7, 1'b1); expect_out("ld_fwd", 0, M_ALL, 1'b0, 0, 2, 1); tick();
        idle_in();                   expect_out("ld_cnt", 0, M_C, 1'b0, 0, 0, 1); tick();

        // two producers of x9: youngest wins; no output when id_valid=0
        do_reset();
        issue(9, 1'b0); tick();
        issue(9, 1'b0); tick();
        read_srcs(9, 1'b1, 9, 1'b1); expect_out("x9_prio", 0, M_ALL, 1'b0, 1, 1, 0); tick();
        set_in(1'b0, 9, 1'b1, 9, 1'b1, 0, 1'b0, 1'b0);
        expect_out("x9_noval", 0, M_ALL, 1'b0, 0, 0, 0); tick();

        // x0 producer is never tracked
        do_reset();
        set_in(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1); tick();
        read_srcs(0, 1'b1, 0, 1'b1); expect_out("x0", 0, M_ALL, 1'b0, 0, 0, 0); tick();

        // flush kills load x4 in EX and the load x4 in ID
        do_reset();
        issue(4, 1'b1); tick();
        issue(4, 1'b1); flush = 1'b1; tick();
        flush = 1'b0;
        read_srcs(4, 1'b1, 0, 1'b0); expect_out("flush", 0, M_ALL, 1'b0, 0, 0, 0); tick();

        // flush during 3 cycles of mem_wait, applied on release
        do_reset();
        issue(4, 1'b1); tick();
        idle_in(); mem_wait = 1'b1; flush = 1'b1;
        expect_out("mw1", 0, M_S | M_C, 1'b1, 0, 0, 0); tick();
        read_srcs(4, 1'b1, 0, 1'b0); flush = 1'b0;
        expect_out("mw2_frozen", 0, M_ALL, 1'b1, 1, 0, 1); tick();
        idle_in(); mem_wait = 1'b1;
        expect_out("mw3", 0, M_S | M_C, 1'b1, 0, 0, 2); tick();
        idle_in();
        expect_out("mw_rel", 0, M_ALL, 1'b0, 0, 0, 3); tick();
        read_srcs(4, 1'b1, 0, 1'b0);
        expect_out("mw_flushed", 0, M_ALL, 1'b0, 0, 0, 3); tick();

        // stall-only instance: dependent add stalls until producer is in WB
        do_reset();
        issue(3, 1'b0); tick();
        read_srcs(3, 1'b1, 0, 1'b0); expect_out("nf1", 1, M_ALL, 1'b1, 0, 0, 0); tick();
        read_srcs(3, 1'b1, 0, 1'b0); expect_out("nf2", 1, M_ALL, 1'b1, 0, 0, 1); tick();
        read_srcs(3, 1'b1, 0, 1'b0); expect_out("nf3", 1, M_ALL, 1'b0, 0, 0, 2); tick();

        // 4-bit counter: bring to 14 then saturate at 15
        do_reset();
        idle_in(); mem_wait = 1'b1;
        repeat (14) tick();
        mem_wait = 1'b0;
        expect_out("c4_pre", 2, M_S | M_C, 1'b0, 0, 0, 14); tick();
        mem_wait = 1'b1;
        expect_out("c4_s1", 2, M_S | M_C, 1'b1, 0, 0, 14); tick();
        expect_out("c4_s2", 2, M_S | M_C, 1'b1, 0, 0, 15); tick();
        expect_out("c4_s3", 2, M_S | M_C, 1'b1, 0, 0, 15); tick();
        mem_wait = 1'b0;
        expect_out("c4_sat", 2, M_S | M_C, 1'b0, 0, 0, 15); tick();

        // reset during a load-use stall, with flush and mem_wait asserted
        issue(7, 1'b1); tick();
        read_srcs(0, 1'b0, 7, 1'b1);
        expect_out("c4_ldstall", 2, M_S, 1'b1, 0, 0, 0);
        rst = 1'b1; flush = 1'b1; mem_wait = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; mem_wait = 1'b0;
        expect_out("c4_rst", 2, M_ALL, 1'b0, 0, 0, 0); tick();

        idle_in();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            num_checks++;
            num_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
